ibex_multdiv_arbiter: RTL and testbench

Sequencer and arbiter that shares one `ibex_multdiv_fast` instance between `NumReq` independent requesters, e.g. the main pipeline plus a coprocessor or debug port. The block accepts one M-extension operation at a time and latches its operands. It drives the multdiv enable, select, operator and operand inputs until completion, captures the result, and returns it to the owning requester over a valid/ready response channel. It sits between the requesters and the multdiv datapath; the ALU and intermediate-register wiring to multdiv is unchanged.

---
 rtl/ibex_multdiv_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ibex_multdiv_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_arbiter.sv
// Shares one multdiv datapath between NumReq requesters: accept one op, run it, return the result.
// Define IBEX_MD_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority.
package ibex_pkg;
  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;
endpackage

module ibex_multdiv_arbiter #(
  parameter int NumReq = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i       [NumReq],
  output logic             req_ready_o       [NumReq],
  input  ibex_pkg::md_op_e req_op_i          [NumReq],
  input  logic [1:0]       req_signed_mode_i [NumReq],
  input  logic [31:0]      req_a_i           [NumReq],
  input  logic [31:0]      req_b_i           [NumReq],
  output logic             rsp_valid_o       [NumReq],
  output logic [31:0]      rsp_result_o      [NumReq],
  input  logic             rsp_ready_i       [NumReq],
  output logic             md_mult_en_o,
  output logic             md_div_en_o,
  output logic             md_mult_sel_o,
  output logic             md_div_sel_o,
  output ibex_pkg::md_op_e md_operator_o,
  output logic [1:0]       md_signed_mode_o,
  output logic [31:0]      md_op_a_o,
  output logic [31:0]      md_op_b_o,
  output logic             md_ready_id_o,
  input  logic             md_valid_i,
  input  logic [31:0]      md_result_i
);
  import ibex_pkg::*;

  localparam int IdxW = $clog2(NumReq);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q;
  logic [IdxW-1:0] grant_idx;
  logic            grant_any;
  logic            accept;
  int              start;
  int              cand;
  md_op_e          op_q;
  logic [1:0]      mode_q;
  logic [31:0]     a_q, b_q, result_q;
  logic            busy, is_mult, is_div;

`ifdef IBEX_MD_ARB_ROUND_ROBIN_EN
  // Pointer holds the last granted index; reset value makes requester 0 win first.
  logic [IdxW-1:0] ptr_q;

  always_comb begin
    start = int'(ptr_q) + 1;
    if (start >= NumReq) start = 0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= IdxW'(NumReq - 1);
    end else if (accept) begin
      ptr_q <= grant_idx;
    end
  end
`else
  assign start = 0;
`endif

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < NumReq; k++) begin
      cand = (start + k) % NumReq;
      if (!grant_any && req_valid_i[cand]) begin
        grant_any = 1'b1;
        grant_idx = IdxW'(cand);
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_any;

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = accept && (grant_idx == IdxW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_any) state_d = BUSY;
      BUSY:    if (md_valid_i) state_d = RESP;
      RESP:    if (rsp_ready_i[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operation latch on accept, result capture on multdiv completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q  <= '0;
      op_q     <= MD_OP_MULL;
      mode_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        owner_q <= grant_idx;
        op_q    <= req_op_i[grant_idx];
        mode_q  <= req_signed_mode_i[grant_idx];
        a_q     <= req_a_i[grant_idx];
        b_q     <= req_b_i[grant_idx];
      end
      if ((state_q == BUSY) && md_valid_i) begin
        result_q <= md_result_i;
      end
    end
  end

  assign busy    = (state_q == BUSY);
  assign is_mult = (op_q == MD_OP_MULL) || (op_q == MD_OP_MULH);
  assign is_div  = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);

  assign md_mult_en_o     = busy && is_mult;
  assign md_mult_sel_o    = busy && is_mult;
  assign md_div_en_o      = busy && is_div;
  assign md_div_sel_o     = busy && is_div;
  assign md_ready_id_o    = busy;
  assign md_operator_o    = op_q;
  assign md_signed_mode_o = mode_q;
  assign md_op_a_o        = a_q;
  assign md_op_b_o        = b_q;

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      rsp_valid_o[i]  = (state_q == RESP) && (owner_q == IdxW'(i));
      rsp_result_o[i] = result_q;
    end
  end

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Directed bench for ibex_multdiv_arbiter with a fixed-latency behavioural multdiv stand-in.
module tb_ibex_multdiv_arbiter;
  import ibex_pkg::*;

  localparam int N   = 2;
  localparam int Lat = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [N];
  logic        req_ready  [N];
  md_op_e      req_op     [N];
  logic [1:0]  req_mode   [N];
  logic [31:0] req_a      [N];
  logic [31:0] req_b      [N];
  logic        rsp_valid  [N];
  logic [31:0] rsp_result [N];
  logic        rsp_ready  [N];
  logic        md_mult_en, md_div_en, md_mult_sel, md_div_sel, md_ready_id;
  md_op_e      md_operator;
  logic [1:0]  md_signed_mode;
  logic [31:0] md_op_a, md_op_b;
  logic        md_valid;
  logic [31:0] md_result;

  int checks   = 0;
  int failures = 0;
  int cnt;

  always #5 clk = ~clk;

  ibex_multdiv_arbiter #(.NumReq(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_signed_mode_i(req_mode), .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_result_o(rsp_result), .rsp_ready_i(rsp_ready),
    .md_mult_en_o(md_mult_en), .md_div_en_o(md_div_en),
    .md_mult_sel_o(md_mult_sel), .md_div_sel_o(md_div_sel),
    .md_operator_o(md_operator), .md_signed_mode_o(md_signed_mode),
    .md_op_a_o(md_op_a), .md_op_b_o(md_op_b), .md_ready_id_o(md_ready_id),
    .md_valid_i(md_valid), .md_result_i(md_result)
  );

  // Stand-in multdiv: valid after Lat enabled cycles, arithmetic from the operator.
  function automatic logic [31:0] md_model(md_op_e op, logic [1:0] mode, logic [31:0] a, logic [31:0] b);
    logic signed [32:0] sa, sb;
    logic signed [65:0] p;
    sa = $signed({mode[0] & a[31], a});
    sb = $signed({mode[1] & b[31], b});
    p  = sa * sb;
    case (op)
      MD_OP_MULL: return p[31:0];
      MD_OP_MULH: return p[63:32];
      MD_OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (mode == 2'b11) return $signed(a) / $signed(b);
        return a / b;
      end
      default: begin
        if (b == 32'd0) return a;
        if (mode == 2'b11) return $signed(a) % $signed(b);
        return a % b;
      end
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst || !(md_mult_en || md_div_en)) cnt <= 0;
    else cnt <= cnt + 1;
  end

  assign md_valid  = (md_mult_en || md_div_en) && (cnt == Lat - 1);
  assign md_result = md_model(md_operator, md_signed_mode, md_op_a, md_op_b);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_op[i]    = MD_OP_MULL;
      req_mode[i]  = 2'b00;
      req_a[i]     = 32'd0;
      req_b[i]     = 32'd0;
      rsp_ready[i] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input int idx, input int bound, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < bound) begin
      if (rsp_valid[idx] === 1'b1) ok = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
  endtask

  task automatic issue_and_wait(input int idx, input md_op_e op, input logic [1:0] mode,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output bit ok);
    int n;
    bit ok2;
    rsp_ready[idx] = 1'b1;
    req_op[idx]    = op;
    req_mode[idx]  = mode;
    req_a[idx]     = a;
    req_b[idx]     = b;
    req_valid[idx] = 1'b1;
    #1;
    n = 0;
    while (req_ready[idx] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    ok = (req_ready[idx] === 1'b1);
    step();
    req_valid[idx] = 1'b0;
    wait_rsp(idx, 50, n, ok2);
    ok  = ok && ok2;
    res = rsp_result[idx];
    step();
    rsp_ready[idx] = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    checks++;
    if ({req_ready[0], req_ready[1]} !== 2'b00) begin
      failures++; $display("FAIL reset_req_ready: got %b expected 00", {req_ready[0], req_ready[1]});
    end
    checks++;
    if ({rsp_valid[0], rsp_valid[1]} !== 2'b00) begin
      failures++; $display("FAIL reset_rsp_valid: got %b expected 00", {rsp_valid[0], rsp_valid[1]});
    end
    checks++;
    if ({md_mult_en, md_div_en, md_mult_sel, md_div_sel, md_ready_id} !== 5'b0) begin
      failures++;
      $display("FAIL reset_md_ctrl: got %b expected 00000",
               {md_mult_en, md_div_en, md_mult_sel, md_div_sel, md_ready_id});
    end
    checks++;
    if ({md_op_a, md_op_b} !== 64'd0) begin
      failures++; $display("FAIL reset_operands: got %h %h expected 0 0", md_op_a, md_op_b);
    end
    checks++;
    if ({md_operator, md_signed_mode} !== 4'd0) begin
      failures++; $display("FAIL reset_operator: got %h %b expected 0 00", md_operator, md_signed_mode);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_mul();
    int  cyc;
    bit  ok;
    apply_reset();
    req_op[0] = MD_OP_MULL; req_mode[0] = 2'b00; req_a[0] = 32'd3; req_b[0] = 32'd5;
    req_valid[0] = 1'b1;
    #1;
    checks++;
    if ({req_ready[0], req_ready[1], md_mult_en} !== 3'b100) begin
      failures++;
      $display("FAIL mul_accept: ready0/ready1/mult_en got %b expected 100", {req_ready[0], req_ready[1], md_mult_en});
    end
    step();
    req_valid[0] = 1'b0;
    #1;
    checks++;
    if ({req_ready[0], md_mult_en, md_mult_sel, md_div_en, md_ready_id} !== 5'b01101) begin
      failures++;
      $display("FAIL mul_busy_ctrl: got %b expected 01101",
               {req_ready[0], md_mult_en, md_mult_sel, md_div_en, md_ready_id});
    end
    wait_rsp(0, 20, cyc, ok);
    checks++;
    if (!ok || (cyc + 1) != Lat + 1) begin
      failures++; $display("FAIL mul_latency: got %0d (seen=%0d) expected %0d", cyc + 1, ok, Lat + 1);
    end
    checks++;
    if (rsp_result[0] !== 32'd15 || md_mult_en !== 1'b0) begin
      failures++; $display("FAIL mul_result: got %h en=%b expected 0000000f en=0", rsp_result[0], md_mult_en);
    end
    rsp_ready[0] = 1'b1;
    step();
    checks++;
    if (rsp_valid[0] !== 1'b0) begin
      failures++; $display("FAIL mul_handshake: rsp_valid got %b expected 0", rsp_valid[0]);
    end
    rsp_ready[0] = 1'b0;
  endtask

  task automatic test_simultaneous();
    int cyc, got, n;
    bit ok, found;
    int exp_g [3];
`ifdef IBEX_MD_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0};
`else
    exp_g = '{0, 0, 0};
`endif
    apply_reset();
    req_op[0] = MD_OP_DIV; req_mode[0] = 2'b11; req_a[0] = 32'd100; req_b[0] = 32'd7;
    req_op[1] = MD_OP_REM; req_mode[1] = 2'b11; req_a[1] = 32'd100; req_b[1] = 32'd7;
    rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    #1;
    checks++;
    if ({req_ready[0], req_ready[1]} !== 2'b10) begin
      failures++; $display("FAIL sim_first_grant: got %b expected 10", {req_ready[0], req_ready[1]});
    end
    step();
    req_valid[0] = 1'b0;
    wait_rsp(0, 20, cyc, ok);
    checks++;
    if (!ok || rsp_result[0] !== 32'd14) begin
      failures++; $display("FAIL sim_div_result: got %h seen=%0d expected 0000000e", rsp_result[0], ok);
    end
    step();
    checks++;
    if ({req_ready[0], req_ready[1]} !== 2'b01) begin
      failures++; $display("FAIL sim_second_grant: got %b expected 01", {req_ready[0], req_ready[1]});
    end
    step();
    req_valid[1] = 1'b0;
    wait_rsp(1, 20, cyc, ok);
    checks++;
    if (!ok || rsp_result[1] !== 32'd2) begin
      failures++; $display("FAIL sim_rem_result: got %h seen=%0d expected 00000002", rsp_result[1], ok);
    end
    step();

    // Both keep requesting: grant order shows the arbitration policy.
    req_op[0] = MD_OP_MULL; req_mode[0] = 2'b00; req_a[0] = 32'd6; req_b[0] = 32'd7;
    req_op[1] = MD_OP_MULL; req_mode[1] = 2'b00; req_a[1] = 32'd3; req_b[1] = 32'd3;
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (req_ready[0] !== 1'b1 && req_ready[1] !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      found = (req_ready[0] === 1'b1) || (req_ready[1] === 1'b1);
      got   = (req_ready[1] === 1'b1) ? 1 : 0;
      checks++;
      if (!found || got != exp_g[g]) begin
        failures++; $display("FAIL rr_grant_%0d: got %0d found=%0d expected %0d", g, got, found, exp_g[g]);
      end
      step();
      if (g == 2) begin
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      end
      wait_rsp(got, 20, cyc, ok);
      checks++;
      if (!ok || rsp_result[got] !== ((got == 0) ? 32'd42 : 32'd9)) begin
        failures++; $display("FAIL rr_result_%0d: got %h seen=%0d requester %0d", g, rsp_result[got], ok, got);
      end
      step();
    end
    rsp_ready[0] = 1'b0; rsp_ready[1] = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    req_op[0] = MD_OP_MULH; req_mode[0] = 2'b11;
    req_a[0] = 32'h8000_0000; req_b[0] = 32'h8000_0000;
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1) begin
      failures++; $display("FAIL bp_accept: ready0 got %b expected 1", req_ready[0]);
    end
    step();
    req_valid[0] = 1'b0;
    req_op[1] = MD_OP_MULL; req_mode[1] = 2'b00; req_a[1] = 32'd2; req_b[1] = 32'd3;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    wait_rsp(0, 20, cyc, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL bp_rsp_timeout: rsp_valid0 got 0 expected 1");
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({rsp_valid[0], rsp_valid[1], req_ready[0], req_ready[1], rsp_result[0]} !== {4'b1000, 32'h4000_0000}) begin
        failures++;
        $display("FAIL bp_hold_%0d: vld0/vld1/rdy0/rdy1 got %b result %h expected 1000 40000000", c,
                 {rsp_valid[0], rsp_valid[1], req_ready[0], req_ready[1]}, rsp_result[0]);
      end
      step();
    end
    rsp_ready[0] = 1'b1;
    step();
    checks++;
    if ({rsp_valid[0], req_ready[1]} !== 2'b01) begin
      failures++; $display("FAIL bp_release: vld0/rdy1 got %b expected 01", {rsp_valid[0], req_ready[1]});
    end
    rsp_ready[0] = 1'b0;
    step();
    req_valid[1] = 1'b0;
    wait_rsp(1, 20, cyc, ok);
    checks++;
    if (!ok || rsp_result[1] !== 32'd6) begin
      failures++; $display("FAIL bp_second_result: got %h seen=%0d expected 00000006", rsp_result[1], ok);
    end
    step();
    rsp_ready[1] = 1'b0;
  endtask

  task automatic test_div_by_zero();
    logic [31:0] res;
    bit          ok;
    issue_and_wait(0, MD_OP_DIV, 2'b11, 32'h0000_1234, 32'd0, res, ok);
    checks++;
    if (!ok || res !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL div0_quotient: got %h seen=%0d expected ffffffff", res, ok);
    end
    issue_and_wait(0, MD_OP_REM, 2'b11, 32'h0000_1234, 32'd0, res, ok);
    checks++;
    if (!ok || res !== 32'h0000_1234) begin
      failures++; $display("FAIL div0_remainder: got %h seen=%0d expected 00001234", res, ok);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    bit          ok, seen;
    req_op[0] = MD_OP_DIV; req_mode[0] = 2'b11; req_a[0] = 32'd1000; req_b[0] = 32'd3;
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    #1;
    checks++;
    if ({md_div_en, md_ready_id} !== 2'b11) begin
      failures++; $display("FAIL rmid_busy: div_en/ready_id got %b expected 11", {md_div_en, md_ready_id});
    end
    rst = 1'b1;
    step();
    checks++;
    if ({md_div_en, md_div_sel, md_mult_en, md_ready_id, rsp_valid[0], req_ready[0]} !== 6'b0) begin
      failures++;
      $display("FAIL rmid_ctrl: got %b expected 000000",
               {md_div_en, md_div_sel, md_mult_en, md_ready_id, rsp_valid[0], req_ready[0]});
    end
    checks++;
    if ({md_op_a, md_op_b, md_operator, md_signed_mode} !== 68'd0) begin
      failures++;
      $display("FAIL rmid_regs: a=%h b=%h op=%h mode=%b expected all 0", md_op_a, md_op_b, md_operator, md_signed_mode);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid[0] === 1'b1) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL rmid_no_rsp: rsp_valid seen %b expected 0", seen);
    end
    issue_and_wait(0, MD_OP_MULL, 2'b00, 32'd2, 32'd2, res, ok);
    checks++;
    if (!ok || res !== 32'd4) begin
      failures++; $display("FAIL rmid_new_mul: got %h seen=%0d expected 00000004", res, ok);
    end
  endtask

  initial begin
    test_reset();
    test_single_mul();
    test_simultaneous();
    test_backpressure();
    test_div_by_zero();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
